// File: rtl/sdram_responder.sv
// Avalon-MM slave that behaves like a simple SDRAM-backed 16-bit memory with fixed read latency,
// optional periodic waitrequest injection, access counters and a sticky protocol error flag.
module sdram_responder #(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned STALL_EVERY  = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        avs_s0_read,
   input  logic        avs_s0_write,
   input  logic [31:0] avs_s0_address,
   input  logic [15:0] avs_s0_writedata,
   input  logic [1:0]  avs_s0_byteenable,
   output logic [15:0] avs_s0_readdata,
   output logic        avs_s0_readdatavalid,
   output logic        avs_s0_waitrequest,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count,
   output logic        proto_err
);

   localparam int unsigned AddrBits = $clog2(DEPTH_WORDS);
   localparam int unsigned CntW     = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
   localparam logic [CntW-1:0] CntLast = (STALL_EVERY == 0) ? '0 : CntW'(STALL_EVERY - 1);

   if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
      $error("READ_LATENCY must be in 1..8");
   end
   if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("DEPTH_WORDS must be a power of two, at least 2");
   end

   logic [15:0]                   mem [DEPTH_WORDS];
   logic [AddrBits-1:0]           word_idx;
   logic                          addr_bad;
   logic                          req_acc;
   logic                          rd_acc;
   logic                          wr_acc;
   logic                          rd_issue;
   logic                          mem_we;

   logic [CntW-1:0]               stall_cnt_q, stall_cnt_d;
   logic                          waitrequest_q, waitrequest_d;
   logic [15:0]                   rd_count_q, rd_count_d;
   logic [15:0]                   wr_count_q, wr_count_d;
   logic                          proto_err_q, proto_err_d;
   logic [READ_LATENCY-1:0]       pipe_v_q;
   logic [READ_LATENCY-1:0][15:0] pipe_d_q;

   // Decode and acceptance
   assign word_idx = avs_s0_address[AddrBits:1];
   assign addr_bad = avs_s0_address[0] | (|avs_s0_address[31:AddrBits+1]);
   assign req_acc  = (avs_s0_read | avs_s0_write) & ~waitrequest_q;
   assign rd_acc   = avs_s0_read & ~waitrequest_q;
   assign wr_acc   = avs_s0_write & ~waitrequest_q;
   // A read paired with a write in the same beat is dropped; the write wins.
   assign rd_issue = rd_acc & ~avs_s0_write;
   assign mem_we   = wr_acc & ~addr_bad & ~reset;

   // Storage: never reset, byte-lane write enables
   always_ff @(posedge clk) begin
      if (mem_we && avs_s0_byteenable[0]) begin
         mem[word_idx][7:0] <= avs_s0_writedata[7:0];
      end
      if (mem_we && avs_s0_byteenable[1]) begin
         mem[word_idx][15:8] <= avs_s0_writedata[15:8];
      end
   end

   // Read return pipeline; the last stage is the registered readdata/readdatavalid
   always_ff @(posedge clk) begin
      if (reset) begin
         pipe_v_q <= '0;
         pipe_d_q <= '0;
      end else begin
         pipe_v_q[0] <= rd_issue;
         if (rd_issue) begin
            pipe_d_q[0] <= addr_bad ? 16'hDEAD : mem[word_idx];
         end
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_v_q[i] <= pipe_v_q[i-1];
            // Data only moves with a valid word so the output holds between pulses
            if (pipe_v_q[i-1]) begin
               pipe_d_q[i] <= pipe_d_q[i-1];
            end
         end
      end
   end

   // Stall injection counter and registered waitrequest
   always_comb begin
      stall_cnt_d = '0;
      if (STALL_EVERY > 1) begin
         stall_cnt_d = (stall_cnt_q == CntLast) ? '0 : stall_cnt_q + CntW'(1);
      end
   end

   always_comb begin
      waitrequest_d = 1'b0;
      if (STALL_EVERY != 0) begin
         waitrequest_d = (stall_cnt_d == CntLast);
      end
   end

   // Counters and error flag
   always_comb begin
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      if (rd_acc && rd_count_q != 16'hFFFF) begin
         rd_count_d = rd_count_q + 16'd1;
      end
      if (wr_acc && wr_count_q != 16'hFFFF) begin
         wr_count_d = wr_count_q + 16'd1;
      end
      proto_err_d = proto_err_q | (req_acc & ((avs_s0_read & avs_s0_write) | addr_bad));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q   <= '0;
         waitrequest_q <= 1'b1;
         rd_count_q    <= '0;
         wr_count_q    <= '0;
         proto_err_q   <= 1'b0;
      end else begin
         stall_cnt_q   <= stall_cnt_d;
         waitrequest_q <= waitrequest_d;
         rd_count_q    <= rd_count_d;
         wr_count_q    <= wr_count_d;
         proto_err_q   <= proto_err_d;
      end
   end

   assign avs_s0_readdata      = pipe_d_q[READ_LATENCY-1];
   assign avs_s0_readdatavalid = pipe_v_q[READ_LATENCY-1];
   assign avs_s0_waitrequest   = waitrequest_q;
   assign rd_count             = rd_count_q;
   assign wr_count             = wr_count_q;
   assign proto_err            = proto_err_q;

endmodule

// File: doc/sdram_responder.md
SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 16-bit storage words (power of two).
REQ-002 Parameter READ_LATENCY, default 2, is the cycles from read acceptance to readdatavalid (legal 1..8).
REQ-003 Parameter STALL_EVERY, default 0, is the waitrequest injection period; 0 disables injection.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 avs_s0_read  in  1  read request.
REQ-007 avs_s0_write  in  1  write request.
REQ-008 avs_s0_address  in  32  byte address; word index = address[log2(DEPTH_WORDS):1].
REQ-009 avs_s0_writedata  in  16  write data.
REQ-010 avs_s0_byteenable  in  2  bit0 = low byte, bit1 = high byte.
REQ-011 avs_s0_readdata  out  16  registered read data.
REQ-012 avs_s0_readdatavalid  out  1  one-cycle pulse per returned read word.
REQ-013 avs_s0_waitrequest  out  1  registered backpressure.
REQ-014 rd_count  out  16  accepted reads, saturating at 16'hFFFF.
REQ-015 wr_count  out  16  accepted writes, saturating at 16'hFFFF.
REQ-016 proto_err  out  1  sticky protocol/range error flag.

Function
REQ-017 A request SHALL be accepted in a cycle where (read or write) is high and waitrequest is low.
REQ-018 A write is accepted that cycle: byte lanes with byteenable set SHALL update at the clock edge; lanes with byteenable clear are preserved; byteenable 2'b00 changes no data but still counts.
REQ-019 An accepted read SHALL return the full word, ignoring byteenable, with readdatavalid high exactly READ_LATENCY cycles after acceptance.
REQ-020 Reads SHALL be pipelined: one acceptance per cycle, up to READ_LATENCY outstanding, returned in order, no bubbles inserted.
REQ-021 A read accepted in cycle t+1 SHALL observe any write accepted in cycle t or earlier.
REQ-022 When readdatavalid is low, readdata SHALL hold its last value.
REQ-023 Injection counter counts 0..STALL_EVERY-1 every cycle; waitrequest is high in the cycle the counter equals STALL_EVERY-1, otherwise low; it is independent of request inputs.
REQ-024 STALL_EVERY = 0 SHALL keep waitrequest low at all times outside reset and the first post-reset cycle.
REQ-025 A request held under waitrequest SHALL NOT be accepted or counted until waitrequest is low; the master is responsible for holding it.
REQ-026 read and write both high in an accepting cycle: the write is performed, the read is dropped (no readdatavalid), proto_err set.
REQ-027 An address with any bit above log2(DEPTH_WORDS) set, or address[0] = 1: the write is ignored, the read returns 16'hDEAD with normal latency, proto_err set; both still counted.
REQ-028 rd_count and wr_count increment by 1 per acceptance and SHALL hold at 16'hFFFF.
REQ-029 proto_err, once set, SHALL remain set until reset.

Reset
REQ-030 While reset is high: readdatavalid = 0, readdata = 16'h0000, waitrequest = 1, rd_count = 0, wr_count = 0, proto_err = 0, injection counter = 0.
REQ-031 waitrequest SHALL be high in the first cycle after reset deasserts and follow REQ-023/REQ-024 thereafter.
REQ-032 Reset SHALL discard all in-flight reads; no readdatavalid is produced for reads accepted before reset.
REQ-033 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-034 Write 16'h1234 to address 0x1C (be 2'b11), read 0x1C next cycle -> readdatavalid exactly 2 cycles after acceptance, readdata 16'h1234, wr_count 1, rd_count 1.
REQ-035 Write 16'hAAAA to 0x20 (be 2'b11), then 16'h5500 with be 2'b10, then read -> readdata 16'h55AA.
REQ-036 Back-to-back reads of 0x00, 0x02, 0x04, 0x06 on four consecutive cycles, STALL_EVERY 0 -> four consecutive readdatavalid pulses in address order.
REQ-037 STALL_EVERY 4, read held high continuously for 12 cycles -> waitrequest high every 4th cycle, exactly 9 reads accepted, 9 readdatavalid pulses.
REQ-038 Read and write high together; separately, read of address 0x0000_0801 -> proto_err 1, write performed, no data for the dual request, 16'hDEAD for the odd address.
REQ-039 Reset asserted one cycle after read acceptance -> no readdatavalid, all counters 0, memory retains prior data.
